zinput_hub: RTL
===============

ZINPUT_HUB -- requirements
Module: zinput_hub

Interface
REQ-001 Parameter ROWS, default 8: number of keyboard half-rows, each selected by one zah bit.
REQ-002 Parameter COLS, default 5: keys per row.
REQ-003 Parameter MUS_CH, default 4: mouse channels (0 btn, 1 X, 2 Y, 3 wheel).
REQ-004 Parameter EV_DEPTH, default 8: key-event FIFO depth, a power of two and at least 2.
REQ-005 Derived: NK=ROWS*COLS; IDXW=clog2(NK); CHW=clog2(MUS_CH).
REQ-006 fclk  in  1  sole clock; all state changes on the rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 kbd_in  in  NK  key bits, 1=pressed; bit r+ROWS*c is row r, column c.
REQ-009 kbd_stb  in  1  loads kbd_in.
REQ-010 mus_in  in  8  mouse/joystick byte.
REQ-011 mus_stb  in  MUS_CH  one-hot per-channel load strobe.
REQ-012 mus_acc  in  MUS_CH  per-channel mode: 1 means accumulate signed delta, 0 means load.
REQ-013 kj_stb  in  1  loads mus_in[4:0] into kj_data.
REQ-014 zah  in  ROWS  row select, active-low.
REQ-015 mus_sel  in  CHW  mouse channel read select.
REQ-016 ev_rd  in  1  pops one key event.
REQ-017 ev_clr  in  1  clears the FIFO and ovf.
REQ-018 kbd_data  out  COLS  active-low wired-AND of the selected rows.
REQ-019 mus_data  out  8  register of channel mus_sel.
REQ-020 kj_data  out  5  kempston joystick register.
REQ-021 ev_data  out  IDXW+1  head event {press, index}.
REQ-022 ev_empty  out  1  FIFO empty.
REQ-023 ev_ovf  out  1  sticky event-dropped flag.

Function
REQ-024 kbd_data SHALL be combinational: bit c = AND over all r with zah[r]=0 of ~key(r,c); all ones when no row is selected.
REQ-025 mus_data SHALL be a combinational mux of the channel registers; mus_sel >= MUS_CH SHALL read 8'hFF.
REQ-026 On mus_stb[i] with mus_acc[i]=0, channel i SHALL load mus_in.
REQ-027 On mus_stb[i] with mus_acc[i]=1, channel i SHALL become channel i + mus_in, an 8-bit modulo sum (wraps, no saturation).
REQ-028 kbd_stb SHALL load kbd<=kbd_in and set pend<=pend|(kbd^kbd_in).
REQ-029 The scanner SHALL have two states, IDLE and SCAN.
REQ-030 Scanner IDLE->SCAN: the cycle after kbd_stb when the change set is non-zero; idx SHALL be set to 0.
REQ-031 In SCAN, idx SHALL advance by one per cycle; if pend[idx]=1, push {kbd[idx],idx} and clear pend[idx].
REQ-032 Scanner SCAN->IDLE: after idx=NK-1.
REQ-033 kbd_stb during SCAN SHALL merge into pend and restart idx at 0.
REQ-034 An event for index k SHALL be written k+2 cycles after the kbd_stb cycle, when the scan is uninterrupted.
REQ-035 ev_data/ev_empty SHALL update the cycle after the write.
REQ-036 A push while the FIFO is full and ev_rd=0 SHALL drop the event and set ev_ovf; pend SHALL still clear.
REQ-037 A push and ev_rd in the same cycle SHALL both take effect, including when the FIFO is full.
REQ-038 ev_rd while empty SHALL be ignored, with no pointer change.
REQ-039 ev_clr SHALL empty the FIFO and clear ev_ovf; it SHALL have priority over a same-cycle push; scanner state and pend are unaffected.
REQ-040 ev_data SHALL be the head entry when not empty; its value while empty is don't-care.

Reset
REQ-041 Reset SHALL set kbd=0, pend=0, all mouse channels=0, kj_data=0, scanner to IDLE with idx=0, FIFO empty (ev_empty=1), and ev_ovf=0.
REQ-042 Reset mid-scan SHALL discard pending and queued events with no partial push.

Structure
REQ-043 A shared package SHALL hold the scanner state enum, default parameters, and the event-field layout.
REQ-044 The FIFO SHALL be one sub-module, zinput_evfifo (parametrised depth and width, pointers one bit wider than the address).

Verification
REQ-045 Key from reset: kbd_stb with bit 9 set -> one event {1,9} with ev_empty falling at cycle 12; after ev_rd, ev_empty=1.
REQ-046 Matrix read: key bit 9 (row 1, column 1) held, zah=8'hFD -> kbd_data=5'b11101; zah=8'hFF -> 5'b11111.
REQ-047 Overflow: 10 distinct changes, EV_DEPTH=8, no reads -> 8 events queued in ascending index, ev_ovf=1; ev_clr -> empty, ev_ovf=0.
REQ-048 Accumulate: ch1 acc=1, deltas 8'h7F then 8'h05 -> mus_data=8'h84 (mus_sel=1); then 8'hFB -> 8'h7F.
REQ-049 Restart: second kbd_stb at scan idx 20 releasing bit 3 -> event {0,3} queued, no duplicate of an index already pushed.
REQ-050 Reset mid-scan: rst_n low for 1 cycle -> ev_empty=1, mus_data=0, kj_data=0, no further events.

Source files
------------

// File: rtl/zinput_hub_pkg.sv
// Shared types and defaults for the input hub.
// Events are {press, index}: press flag at bit IDXW, key index below it.
package zinput_hub_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } scan_e;

  localparam int ROWS_DEF     = 8;
  localparam int COLS_DEF     = 5;
  localparam int MUS_CH_DEF   = 4;
  localparam int EV_DEPTH_DEF = 8;

  function automatic int ev_width(input int idxw);
    return idxw + 1;
  endfunction

endpackage

// File: rtl/zinput_evfifo.sv
// Key-event FIFO with sticky drop flag.
// Pointers carry one wrap bit above the address.
module zinput_evfifo #(
  parameter int DEPTH = 8,
  parameter int W     = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         wr,
  input  logic [W-1:0] wr_data,
  input  logic         rd,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic         ovf_q, ovf_d;
  logic         full, do_rd, do_wr;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_rd   = rd && !empty;
  // A same-cycle pop frees the slot, so a full FIFO still accepts.
  assign do_wr   = wr && (!full || do_rd);
  assign rd_data = mem_q[rptr_q[AW-1:0]];
  assign ovf     = ovf_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
      ovf_d  = 1'b0;
    end else begin
      if (do_rd) rptr_d = rptr_q + 1'b1;
      if (do_wr) wptr_d = wptr_q + 1'b1;
      if (wr && !do_wr) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !clr) mem_q[wptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/zinput_hub.sv
// Keyboard matrix, mouse/joystick registers and key-change scanner.
// Changed keys are walked in index order and queued as events.
module zinput_hub
  import zinput_hub_pkg::*;
#(
  parameter int ROWS     = ROWS_DEF,
  parameter int COLS     = COLS_DEF,
  parameter int MUS_CH   = MUS_CH_DEF,
  parameter int EV_DEPTH = EV_DEPTH_DEF,
  localparam int NK      = ROWS * COLS,
  localparam int IDXW    = $clog2(NK),
  localparam int CHW     = $clog2(MUS_CH),
  localparam int EW      = ev_width(IDXW)
) (
  input  logic              fclk,
  input  logic              rst_n,
  input  logic [NK-1:0]     kbd_in,
  input  logic              kbd_stb,
  input  logic [7:0]        mus_in,
  input  logic [MUS_CH-1:0] mus_stb,
  input  logic [MUS_CH-1:0] mus_acc,
  input  logic              kj_stb,
  input  logic [ROWS-1:0]   zah,
  input  logic [CHW-1:0]    mus_sel,
  input  logic              ev_rd,
  input  logic              ev_clr,
  output logic [COLS-1:0]   kbd_data,
  output logic [7:0]        mus_data,
  output logic [4:0]        kj_data,
  output logic [EW-1:0]     ev_data,
  output logic              ev_empty,
  output logic              ev_ovf
);

  scan_e           state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [NK-1:0]   kbd_q, kbd_d;
  logic [NK-1:0]   pend_q, pend_d;
  logic [7:0]      mus_q [MUS_CH];
  logic [7:0]      mus_d [MUS_CH];
  logic [4:0]      kj_q, kj_d;
  logic            push;
  logic [EW-1:0]   ev_w;

  assign ev_w    = {kbd_q[idx_q], idx_q};
  assign kj_data = kj_q;

  always_comb begin
    kbd_data = '1;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (!zah[r]) kbd_data[c] = kbd_data[c] & ~kbd_q[r+ROWS*c];
  end

  always_comb begin
    mus_data = 8'hFF;
    if (int'(mus_sel) < MUS_CH) mus_data = mus_q[mus_sel];
  end

  always_comb begin
    for (int i = 0; i < MUS_CH; i++) begin
      mus_d[i] = mus_q[i];
      if (mus_stb[i]) mus_d[i] = mus_acc[i] ? mus_q[i] + mus_in : mus_in;
    end
    kj_d = kj_stb ? mus_in[4:0] : kj_q;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    kbd_d   = kbd_q;
    pend_d  = pend_q;
    push    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!kbd_stb && |pend_q) begin
          state_d = S_SCAN;
          idx_d   = '0;
        end
      end
      S_SCAN: begin
        if (kbd_stb) begin
          idx_d = '0;
        end else begin
          if (pend_q[idx_q]) begin
            push          = 1'b1;
            pend_d[idx_q] = 1'b0;
          end
          if (idx_q == IDXW'(NK-1)) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (kbd_stb) begin
      kbd_d  = kbd_in;
      pend_d = pend_q | (kbd_q ^ kbd_in);
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      kbd_q   <= '0;
      pend_q  <= '0;
      kj_q    <= '0;
      for (int i = 0; i < MUS_CH; i++) mus_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      kbd_q   <= kbd_d;
      pend_q  <= pend_d;
      kj_q    <= kj_d;
      for (int i = 0; i < MUS_CH; i++) mus_q[i] <= mus_d[i];
    end
  end

  zinput_evfifo #(
    .DEPTH (EV_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (fclk),
    .rst_n   (rst_n),
    .clr     (ev_clr),
    .wr      (push),
    .wr_data (ev_w),
    .rd      (ev_rd),
    .rd_data (ev_data),
    .empty   (ev_empty),
    .ovf     (ev_ovf)
  );

endmodule
